conv_window_streamer: RTL and testbench
=======================================

Name: conv_window_streamer

Overview:
- AXI-Stream master that feeds the convolution block's s00 pixel input.
- Reads a grayscale frame from a synchronous image RAM and emits pixels in the window order the convolution expects:
  - first load of each row strip: 9 pixels (3 columns × 3 rows, column-major);
  - then 3 pixels per column step;
  - tlast on the final pixel of each strip.

Parameters:
- ADDR_WIDTH, 12: image RAM address width.
- C_AXIS_TDATA_WIDTH, 32: stream data width.
- PIXEL_NB, 7: pixel bits carried in tdata[PIXEL_NB-1:0].
- IMG_W, 64: image width in pixels (≥3).
- IMG_H, 64: image height in pixels (≥3). IMG_W*IMG_H ≤ 2^ADDR_WIDTH.
- FIFO_DEPTH, 4: output skid FIFO depth (power of 2, ≥4).

Ports:
- m00_axis_aclk, input, 1: single clock for the whole block.
- m00_axis_aresetn, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse; starts a frame when idle.
- busy, output, 1: high from accepted start until done.
- done, output, 1: one-cycle pulse after the last beat handshakes.
- mem_en, output, 1: RAM read enable.
- mem_addr, output, ADDR_WIDTH: RAM read address.
- mem_rdata, input, PIXEL_NB: RAM data, valid exactly 1 cycle after mem_en.
- m00_axis_tdata, output, C_AXIS_TDATA_WIDTH: pixel, zero-extended from PIXEL_NB.
- m00_axis_tstrb, output, C_AXIS_TDATA_WIDTH/8: all ones.
- m00_axis_tvalid, output, 1: beat valid.
- m00_axis_tready, input, 1: downstream ready.
- m00_axis_tlast, output, 1: last beat of a row strip.

Behaviour:
- Reset (async assert, sync release):
  - FSM returns to IDLE; FIFO and all counters clear.
  - Outputs during reset: tvalid=0, tlast=0, tdata=0, busy=0, done=0, mem_en=0, mem_addr=0.
  - Reset mid-frame abandons the frame with no further beats. The next start restarts from pixel (0,0).
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 → RUN; busy rises the next cycle.
  - RUN: issue reads until the final frame address has been issued → DRAIN.
  - DRAIN: wait for FIFO empty and no read in flight → DONE.
  - DONE: done=1 for one cycle → IDLE.
  - start is ignored outside IDLE.
- Scan order:
  - Strip r = 0..IMG_H-3; column c = 0..IMG_W-1; k = 0..2.
  - Address = (r+k)*IMG_W + c.
  - Row base is kept as a register incremented by IMG_W; no multiplier.
  - Beats per strip: 3*IMG_W. Frame total: 3*IMG_W*(IMG_H-2).
  - tlast is attached to the beat for (r, IMG_W-1, k=2).
- Read issue:
  - mem_en=1 only when (FIFO count + reads in flight) < FIFO_DEPTH.
  - Each read's data and tlast tag enter the FIFO one cycle later.
  - Sustained rate is 1 beat/cycle when tready=1.
- Latency: first tvalid at 2 cycles after the start cycle (1 to RUN, 1 for RAM read; the FIFO is first-word-fall-through).
- Handshake:
  - A beat transfers on tvalid & tready.
  - While tvalid=1 & tready=0, tdata and tlast hold stable.
  - tvalid never drops without a transfer.
- Boundary conditions:
  - FIFO full stops issue.
  - Push and pop in the same cycle when full is legal; count is unchanged.
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - done fires in the cycle after the final handshake.

Optional Feature:
- Macro: CONV_STREAMER_PAD_EN.
- Defined: zero-padded scan.
  - Strips r = -1..IMG_H-2 (row window r..r+2); columns c = -1..IMG_W.
  - Out-of-image pixels are pushed as 0 with no RAM read (mem_en=0), still honouring FIFO credit.
  - Beats per strip: 3*(IMG_W+2). Strips: IMG_H.
- Undefined: valid-only scan as above; no padding logic is synthesized.

Test Plan:
1. IMG_W=8, IMG_H=4, RAM[a]=a, tready=1, start → 48 beats:
   - beats 0-8 = 0,8,16,1,9,17,2,10,18;
   - beat 23 = 23 with tlast;
   - beat 24 = 8;
   - beat 47 = 31 with tlast;
   - done 1 cycle after beat 47; busy low the cycle after.
2. Same frame with pseudo-random tready (50%) → identical 48-value sequence; tdata/tlast stable while stalled; no RAM read issued when count + in-flight reads = 4.
3. start pulsed again at beat 10 → ignored; sequence and beat count unchanged; one done pulse.
4. m00_axis_aresetn low at beat 10 → tvalid=0 in the same cycle (async); after release and a new start, the first beat = 0 and 48 beats follow.
5. RAM[a]=0xFF, PIXEL_NB=7 → tdata=0x0000007F; tstrb=4'hF on every beat.
6. CONV_STREAMER_PAD_EN, IMG_W=4, IMG_H=3, RAM[a]=a:
   - first strip begins 0,0,0, 0,0,4, 0,1,5;
   - 54 beats total, tlast on beats 17, 35 and 53.

Source files
------------

// File: rtl/conv_window_streamer.sv
// conv_window_streamer: RAM-to-AXIS 3x3 window scan with FWFT skid FIFO.
// Optional zero-padded scan: define CONV_STREAMER_PAD_EN.
module conv_window_streamer #(
  parameter int ADDR_WIDTH         = 12,
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int PIXEL_NB           = 7,
  parameter int IMG_W              = 64,
  parameter int IMG_H              = 64,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                            m00_axis_aclk,
  input  logic                            m00_axis_aresetn,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            mem_en,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic [PIXEL_NB-1:0]             mem_rdata,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tlast
);

`ifdef CONV_STREAMER_PAD_EN
  localparam int NCOL   = IMG_W + 2;
  localparam int NSTRIP = IMG_H;
`else
  localparam int NCOL   = IMG_W;
  localparam int NSTRIP = IMG_H - 2;
`endif
  localparam int CW   = $clog2(NCOL + 1);
  localparam int SW   = $clog2(NSTRIP + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  localparam addr_t W_A = addr_t'(IMG_W);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  logic clk;
  logic rst_n;
  assign clk   = m00_axis_aclk;
  assign rst_n = m00_axis_aresetn;

  state_t state_q, state_n;

  logic [CW-1:0] col_q;
  logic [1:0]    k_q;
  logic [SW-1:0] strip_q;
  addr_t         row_base_q;

  logic rd_q;
  logic tag_q;

  logic [PIXEL_NB-1:0] fifo_pix [FIFO_DEPTH];
  logic                fifo_last [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CNTW-1:0]     count;

  logic col_end, k_end, strip_end;
  logic beat_last, frame_last;
  logic credit, issue, in_img;
  logic empty, pop, pop_fifo, push;
  int   pend;
  addr_t k_off, addr;
  logic [PIXEL_NB-1:0] rd_pix, out_pix;
  logic                out_last;

  assign col_end    = col_q == CW'(NCOL - 1);
  assign k_end      = k_q == 2'd2;
  assign strip_end  = strip_q == SW'(NSTRIP - 1);
  assign beat_last  = col_end && k_end;
  assign frame_last = beat_last && strip_end;

  assign pend   = int'(count) + int'(rd_q);
  assign credit = pend < FIFO_DEPTH;
  assign issue  = (state_q == RUN) && credit;

`ifdef CONV_STREAMER_PAD_EN
  logic pad_q;
  logic row_ok, col_ok;

  assign row_ok = !((k_q == 2'd0 && strip_q == '0) ||
                    (k_end && strip_end));
  assign col_ok = (col_q != '0) && !col_end;
  assign in_img = row_ok && col_ok;
  assign rd_pix = pad_q ? '0 : mem_rdata;

  // Window top row is one above row_base; column index is biased by one.
  always_comb begin
    k_off = '0;
    unique case (1'b1)
      k_q == 2'd0: k_off = addr_t'(0) - W_A;
      k_q == 2'd1: k_off = '0;
      default:     k_off = W_A;
    endcase
  end
  assign addr = row_base_q + k_off + addr_t'(col_q) - addr_t'(1);
`else
  assign in_img = 1'b1;
  assign rd_pix = mem_rdata;

  always_comb begin
    k_off = '0;
    unique case (1'b1)
      k_q == 2'd0: k_off = '0;
      k_q == 2'd1: k_off = W_A;
      default:     k_off = W_A + W_A;
    endcase
  end
  assign addr = row_base_q + k_off + addr_t'(col_q);
`endif

  assign mem_en   = issue && in_img;
  assign mem_addr = mem_en ? addr : '0;

  // Read data bypasses the FIFO when it is empty (first-word-fall-through).
  assign empty    = count == '0;
  assign out_pix  = empty ? rd_pix : fifo_pix[rd_ptr];
  assign out_last = empty ? tag_q : fifo_last[rd_ptr];

  assign m00_axis_tvalid = !empty || rd_q;
  assign m00_axis_tdata  = m00_axis_tvalid ?
                           C_AXIS_TDATA_WIDTH'(out_pix) : '0;
  assign m00_axis_tlast  = m00_axis_tvalid && out_last;
  assign m00_axis_tstrb  = '1;

  assign pop      = m00_axis_tvalid && m00_axis_tready;
  assign pop_fifo = pop && !empty;
  assign push     = rd_q && !(empty && m00_axis_tready);

  assign busy = state_q != IDLE;
  assign done = state_q == DONE;

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:  if (start) state_n = RUN;
      RUN:   if (issue && frame_last) state_n = DRAIN;
      DRAIN: if (pend == 0 || (pend == 1 && pop)) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      k_q        <= '0;
      strip_q    <= '0;
      row_base_q <= '0;
      rd_q       <= 1'b0;
      tag_q      <= 1'b0;
    end else begin
      state_q <= state_n;
      rd_q    <= issue;
      tag_q   <= issue && beat_last;
      if (state_q == IDLE && start) begin
        col_q      <= '0;
        k_q        <= '0;
        strip_q    <= '0;
        row_base_q <= '0;
      end else if (issue) begin
        if (k_end) begin
          k_q <= '0;
          if (col_end) begin
            col_q      <= '0;
            strip_q    <= strip_q + SW'(1);
            row_base_q <= row_base_q + W_A;
          end else begin
            col_q <= col_q + CW'(1);
          end
        end else begin
          k_q <= k_q + 2'd1;
        end
      end
    end
  end

`ifdef CONV_STREAMER_PAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pad_q <= 1'b0;
    else        pad_q <= issue && !in_img;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pix[i]  <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_pix[wr_ptr]  <= rd_pix;
        fifo_last[wr_ptr] <= tag_q;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop_fifo) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CNTW'(push) - CNTW'(pop_fifo);
    end
  end

endmodule

// File: tb/tb_conv_window_streamer.sv
// tb_conv_window_streamer: directed checks of window scan order,
// handshake, credit, reset and start handling.
module tb_conv_window_streamer;

`ifdef CONV_STREAMER_PAD_EN
  localparam int W   = 4;
  localparam int H   = 3;
  localparam int SPB = 3 * (W + 2);
  localparam int NB  = SPB * H;
`else
  localparam int W   = 8;
  localparam int H   = 4;
  localparam int SPB = 3 * W;
  localparam int NB  = SPB * (H - 2);
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, mem_en;
  logic [11:0] mem_addr;
  logic [6:0]  mem_rdata = '0;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tvalid, tlast;
  logic        tready = 1'b1;

  conv_window_streamer #(
    .ADDR_WIDTH(12), .C_AXIS_TDATA_WIDTH(32), .PIXEL_NB(7),
    .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(4)
  ) dut (
    .m00_axis_aclk(clk),
    .m00_axis_aresetn(rst_n),
    .start(start),
    .busy(busy),
    .done(done),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .m00_axis_tdata(tdata),
    .m00_axis_tstrb(tstrb),
    .m00_axis_tvalid(tvalid),
    .m00_axis_tready(tready),
    .m00_axis_tlast(tlast)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int s_cyc, done_at;
  bit ff_mode = 1'b0;
  bit rand_mode = 1'b0;

  logic [31:0] tdq[$];
  bit          lq[$];
  int          cq[$];
  int done_cnt, stab_bad, strb_bad, credit_bad, n_iss, peak_out;
  bit stall_prev;
  logic [31:0] prev_data;
  logic prev_last;

  logic [7:0] ram_word;
  assign ram_word = ff_mode ? 8'hFF : mem_addr[7:0];

  always @(posedge clk) begin
    cyc++;
    if (mem_en) mem_rdata <= ram_word[6:0];
  end

  always @(posedge clk) begin
    #1;
    if (rand_mode) tready = 1'($urandom_range(0, 1));
  end

  // Beat monitor: samples at the falling edge, handshake lands at next rise.
  always @(negedge clk) begin
    if (rst_n) begin
      int outst;
      outst = n_iss - tdq.size();
      if (outst > peak_out) peak_out = outst;
      if (mem_en && outst >= 4) credit_bad++;
      if (mem_en) n_iss++;
      if (stall_prev &&
          (!tvalid || tdata !== prev_data || tlast !== prev_last))
        stab_bad++;
      stall_prev = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
      if (tvalid && tready) begin
        tdq.push_back(tdata);
        lq.push_back(tlast);
        cq.push_back(cyc);
        if (tstrb !== 4'hF) strb_bad++;
      end
      if (done) done_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  function automatic int exp_pix(int i);
    int s, r, c, k;
    s = i / SPB;
    r = i % SPB;
    c = r / 3;
    k = r % 3;
`ifdef CONV_STREAMER_PAD_EN
    if (s - 1 + k < 0 || s - 1 + k >= H || c - 1 < 0 || c - 1 >= W)
      return 0;
    return (s - 1 + k) * W + (c - 1);
`else
    return (s + k) * W + c;
`endif
  endfunction

  task automatic clear_mon();
    tdq.delete();
    lq.delete();
    cq.delete();
    done_cnt   = 0;
    stab_bad   = 0;
    strb_bad   = 0;
    credit_bad = 0;
    n_iss      = 0;
    peak_out   = 0;
    stall_prev = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    clear_mon();
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 4000) begin
      @(negedge clk);
      n++;
      if (done) ok = 1'b1;
    end
    done_at = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    total++;
    if (tvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_tvalid got=%b want=0", tvalid);
    end
    total++;
    if (tdata !== 32'h0 || tlast !== 1'b0) begin
      bad++;
      $display("FAIL reset_tdata got=%h/%b want=0/0", tdata, tlast);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy_done got=%b%b want=00", busy, done);
    end
    total++;
    if (mem_en !== 1'b0 || mem_addr !== 12'h0) begin
      bad++;
      $display("FAIL reset_mem got=%b/%h want=0/000", mem_en, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (tvalid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got=%b%b want=00", tvalid, busy);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int hand[9] = '{0, 8, 16, 1, 9, 17, 2, 10, 18};
    rand_mode = 1'b0;
    tready = 1'b1;
    ff_mode = 1'b0;
    pulse_start();
    wait_done(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_timeout got=no_done want=done");
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy_after got=%b%b want=00", busy, done);
    end
    total++;
    if (tdq.size() != NB) begin
      bad++;
      $display("FAIL basic_count got=%0d want=%0d", tdq.size(), NB);
    end
    total++;
    if (cq.size() == 0 || cq[0] != s_cyc + 2) begin
      bad++;
      $display("FAIL basic_latency got=%0d want=%0d",
               cq.size() ? cq[0] - s_cyc : -1, 2);
    end
    for (int i = 0; i < 9; i++) begin
      total++;
      if (tdq[i] !== 32'(hand[i])) begin
        bad++;
        $display("FAIL basic_beat%0d got=%0d want=%0d", i, tdq[i], hand[i]);
      end
    end
    total++;
    if (tdq[23] !== 32'd23 || lq[23] !== 1'b1) begin
      bad++;
      $display("FAIL basic_beat23 got=%0d/%b want=23/1", tdq[23], lq[23]);
    end
    total++;
    if (tdq[24] !== 32'd8 || lq[24] !== 1'b0) begin
      bad++;
      $display("FAIL basic_beat24 got=%0d/%b want=8/0", tdq[24], lq[24]);
    end
    total++;
    if (tdq[47] !== 32'd31 || lq[47] !== 1'b1) begin
      bad++;
      $display("FAIL basic_beat47 got=%0d/%b want=31/1", tdq[47], lq[47]);
    end
    total++;
    if (cq.size() != NB || done_at != cq[NB-1] + 1) begin
      bad++;
      $display("FAIL basic_done_cycle got=%0d want=%0d",
               done_at, cq.size() ? cq[cq.size()-1] + 1 : -1);
    end
  endtask

  task automatic test_random_tready();
    bit ok;
    int seq_bad;
    ff_mode = 1'b0;
    rand_mode = 1'b1;
    pulse_start();
    wait_done(ok);
    rand_mode = 1'b0;
    tready = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rand_timeout got=no_done want=done");
    end
    total++;
    if (tdq.size() != NB) begin
      bad++;
      $display("FAIL rand_count got=%0d want=%0d", tdq.size(), NB);
    end
    seq_bad = 0;
    for (int i = 0; i < tdq.size(); i++)
      if (tdq[i] !== 32'(exp_pix(i)) || lq[i] !== ((i % SPB) == SPB - 1))
        seq_bad++;
    total++;
    if (seq_bad != 0) begin
      bad++;
      $display("FAIL rand_sequence got=%0d_wrong want=0", seq_bad);
    end
    total++;
    if (stab_bad != 0) begin
      bad++;
      $display("FAIL rand_stall_stable got=%0d want=0", stab_bad);
    end
`ifndef CONV_STREAMER_PAD_EN
    total++;
    if (credit_bad != 0 || peak_out != 4) begin
      bad++;
      $display("FAIL rand_credit got=%0d/peak%0d want=0/peak4",
               credit_bad, peak_out);
    end
`endif
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL rand_done_cnt got=%0d want=1", done_cnt);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    int n, seq_bad;
    ff_mode = 1'b0;
    tready = 1'b1;
    pulse_start();
    n = 0;
    while (tdq.size() < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    repeat (10) @(negedge clk);
    total++;
    if (!ok || n >= 200) begin
      bad++;
      $display("FAIL restart_timeout got=%0d want=done", n);
    end
    seq_bad = 0;
    for (int i = 0; i < tdq.size(); i++)
      if (tdq[i] !== 32'(exp_pix(i))) seq_bad++;
    total++;
    if (tdq.size() != NB || seq_bad != 0) begin
      bad++;
      $display("FAIL restart_sequence got=%0d/%0d want=%0d/0",
               tdq.size(), seq_bad, NB);
    end
    total++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL restart_done got=%0d/%b want=1/0", done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    logic v_before;
    ff_mode = 1'b0;
    tready = 1'b1;
    pulse_start();
    n = 0;
    while (tdq.size() < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    #2;
    v_before = tvalid;
    rst_n = 1'b0;
    #1;
    total++;
    if (v_before !== 1'b1 || tvalid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_tvalid got=%b->%b want=1->0", v_before, tvalid);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (tvalid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_quiet got=%b%b want=00", tvalid, busy);
    end
    pulse_start();
    wait_done(ok);
    total++;
    if (!ok || tdq.size() != NB) begin
      bad++;
      $display("FAIL midreset_count got=%0d want=%0d", tdq.size(), NB);
    end
    total++;
    if (tdq.size() == 0 || tdq[0] !== 32'd0) begin
      bad++;
      $display("FAIL midreset_first got=%0d want=0",
               tdq.size() ? tdq[0] : 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int vbad;
    ff_mode = 1'b1;
    tready = 1'b1;
    pulse_start();
    wait_done(ok);
    ff_mode = 1'b0;
    vbad = 0;
    for (int i = 0; i < tdq.size(); i++)
      if (tdq[i] !== 32'h0000_007F) vbad++;
    total++;
    if (!ok || tdq.size() != NB || vbad != 0) begin
      bad++;
      $display("FAIL sat_tdata got=%0d_beats/%0d_wrong want=%0d/0",
               tdq.size(), vbad, NB);
    end
    total++;
    if (strb_bad != 0) begin
      bad++;
      $display("FAIL sat_tstrb got=%0d_wrong want=0", strb_bad);
    end
  endtask

`ifdef CONV_STREAMER_PAD_EN
  task automatic test_pad();
    bit ok;
    int lbad;
    int hand[9] = '{0, 0, 0, 0, 0, 4, 0, 1, 5};
    ff_mode = 1'b0;
    tready = 1'b1;
    pulse_start();
    wait_done(ok);
    total++;
    if (!ok || tdq.size() != 54) begin
      bad++;
      $display("FAIL pad_count got=%0d want=54", tdq.size());
    end
    for (int i = 0; i < 9; i++) begin
      total++;
      if (tdq[i] !== 32'(hand[i])) begin
        bad++;
        $display("FAIL pad_beat%0d got=%0d want=%0d", i, tdq[i], hand[i]);
      end
    end
    lbad = 0;
    for (int i = 0; i < tdq.size(); i++)
      if (lq[i] !== (i == 17 || i == 35 || i == 53)) lbad++;
    total++;
    if (lbad != 0) begin
      bad++;
      $display("FAIL pad_tlast got=%0d_wrong want=0", lbad);
    end
  endtask
`endif

  initial begin
    clear_mon();
    test_reset();
`ifdef CONV_STREAMER_PAD_EN
    test_pad();
    test_random_tready();
`else
    test_basic();
    test_random_tready();
    test_start_ignored();
    test_reset_mid();
    test_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
